// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for load data from the data SRAM,
// extracts/extends the loaded byte/half/word and hands the result to WB.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_to_mem_valid,
  output logic        mem_allowin,
  input  logic [31:0] ex_pc,
  input  logic [41:0] ex_mem_zip,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [37:0] mem_rf_zip,
  output logic [37:0] mem_fwd_zip,
  output logic        mem_ld_block
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [41:0] zip;
  logic [31:0] ld_buf;

  logic        mem_valid;
  logic        mem_ready_go;
  logic        accept;
  logic        res_from_mem;
  logic [2:0]  ld_op;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] rf_wdata;

  assign res_from_mem = zip[41];
  assign ld_op        = zip[40:38];
  assign rf_we        = zip[37];
  assign rf_waddr     = zip[36:32];
  assign alu_result   = zip[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A new accept always wins; otherwise drain to IDLE on handoff, or park
  // in HOLD when load data arrives while WB is stalled.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = ex_mem_zip[41] ? S_WAIT : S_HOLD;
    end else begin
      case (state)
        S_WAIT: if (data_sram_data_ok) state_next = wb_allowin ? S_IDLE : S_HOLD;
        S_HOLD: if (wb_allowin) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_valid       = (state != S_IDLE);
    mem_ready_go    = (state == S_HOLD) || ((state == S_WAIT) && data_sram_data_ok);
    mem_to_wb_valid = mem_valid & mem_ready_go;
    mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
    accept          = ex_to_mem_valid & mem_allowin;
    mem_ld_block    = mem_valid & res_from_mem & ~mem_ready_go;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_pc <= 32'd0;
      zip    <= 42'd0;
    end else if (accept) begin
      mem_pc <= ex_pc;
      zip    <= ex_mem_zip;
    end
  end

  // Load data arriving while WB stalls must survive rdata changing afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_buf <= 32'd0;
    end else if ((state == S_WAIT) && data_sram_data_ok && !wb_allowin) begin
      ld_buf <= ld_data;
    end
  end

  always_comb begin
    case (alu_result[1:0])
      2'd0:    ld_byte = data_sram_rdata[7:0];
      2'd1:    ld_byte = data_sram_rdata[15:8];
      2'd2:    ld_byte = data_sram_rdata[23:16];
      default: ld_byte = data_sram_rdata[31:24];
    endcase
    ld_half = alu_result[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (ld_op)
      3'b001:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b011:  ld_data = {24'd0, ld_byte};
      3'b100:  ld_data = {16'd0, ld_half};
      default: ld_data = data_sram_rdata;
    endcase
  end

  always_comb begin
    if (!res_from_mem)        rf_wdata = alu_result;
    else if (state == S_HOLD) rf_wdata = ld_buf;
    else                      rf_wdata = ld_data;
    mem_rf_zip  = {rf_we, rf_waddr, rf_wdata};
    mem_fwd_zip = {mem_valid & rf_we, rf_waddr, rf_wdata};
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random traffic, all checked
// against a slot-level behavioural model of the MEM stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_to_mem_valid;
  logic        mem_allowin;
  logic [31:0] ex_pc;
  logic [41:0] ex_mem_zip;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [37:0] mem_rf_zip;
  logic [37:0] mem_fwd_zip;
  logic        mem_ld_block;

  int errors = 0;
  int checks = 0;

  // Model of the single MEM slot: what it holds and whether load data is captured.
  logic        m_occ;
  logic [31:0] m_pc;
  logic        m_rfm;
  logic [2:0]  m_ldop;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_alu;
  logic        m_hasbuf;
  logic [31:0] m_buf;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .mem_allowin       (mem_allowin),
    .ex_pc             (ex_pc),
    .ex_mem_zip        (ex_mem_zip),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_pc            (mem_pc),
    .mem_rf_zip        (mem_rf_zip),
    .mem_fwd_zip       (mem_fwd_zip),
    .mem_ld_block      (mem_ld_block)
  );

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] addr,
                                          input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (int'(addr) * 8)) & 32'hFF;
    h = (rd >> (int'(addr[1]) * 16)) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [41:0] mk_zip(input logic rfm, input logic [2:0] op, input logic we,
                                         input logic [4:0] wa, input logic [31:0] alu);
    return {rfm, op, we, wa, alu};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_occ = 1'b0; m_pc = '0; m_rfm = 1'b0; m_ldop = '0; m_we = 1'b0;
    m_waddr = '0; m_alu = '0; m_hasbuf = 1'b0; m_buf = '0;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [41:0] z,
                                input logic dok, input logic [31:0] rd, input logic wba);
    ex_to_mem_valid   = v;
    ex_pc             = pc;
    ex_mem_zip        = z;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    wb_allowin        = wba;
    #1;
  endtask

  // Compare every output against the model, then clock and advance the model.
  task automatic clock_step();
    logic        rdy;
    logic        alw;
    logic [31:0] wd;
    rdy = m_occ & (!m_rfm | m_hasbuf | data_sram_data_ok);
    alw = !m_occ | (rdy & wb_allowin);
    wd  = m_rfm ? (m_hasbuf ? m_buf : extract(m_ldop, m_alu[1:0], data_sram_rdata)) : m_alu;
    check_output("to_wb", 64'(mem_to_wb_valid), 64'(rdy));
    check_output("allowin", 64'(mem_allowin), 64'(alw));
    check_output("ld_block", 64'(mem_ld_block), 64'(m_occ & m_rfm & !rdy));
    check_output("fwd_we", 64'(mem_fwd_zip[37]), 64'(m_occ & m_we));
    if (m_occ) begin
      check_output("pc", 64'(mem_pc), 64'(m_pc));
      check_output("rf_zip", 64'(mem_rf_zip), 64'({m_we, m_waddr, wd}));
      check_output("fwd_data", 64'(mem_fwd_zip[36:0]), 64'({m_waddr, wd}));
    end
    @(posedge clk);
    if (ex_to_mem_valid & alw) begin
      m_occ = 1'b1; m_pc = ex_pc; m_rfm = ex_mem_zip[41]; m_ldop = ex_mem_zip[40:38];
      m_we = ex_mem_zip[37]; m_waddr = ex_mem_zip[36:32]; m_alu = ex_mem_zip[31:0];
      m_hasbuf = 1'b0;
    end else if (rdy & wb_allowin) begin
      m_occ = 1'b0;
    end else if (m_occ & m_rfm & !m_hasbuf & data_sram_data_ok) begin
      m_hasbuf = 1'b1;
      m_buf    = extract(m_ldop, m_alu[1:0], data_sram_rdata);
    end
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    #1;
    check_output({tag, "_to_wb"}, 64'(mem_to_wb_valid), 64'd0);
    check_output({tag, "_allowin"}, 64'(mem_allowin), 64'd1);
    check_output({tag, "_ld_block"}, 64'(mem_ld_block), 64'd0);
    check_output({tag, "_fwd_we"}, 64'(mem_fwd_zip[37]), 64'd0);
    check_output({tag, "_pc"}, 64'(mem_pc), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [41:0] z;
    reset = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    model_reset();
    async_reset_check("reset");

    // ALU op handed straight to WB.
    apply_stimulus(1'b1, 32'h1c000000, mk_zip(1'b0, 3'd0, 1'b1, 5'd5, 32'h12345678), 1'b0, '0, 1'b1);
    clock_step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    check_output("alu_to_wb", 64'(mem_to_wb_valid), 64'd1);
    check_output("alu_zip", 64'(mem_rf_zip), 64'({1'b1, 5'd5, 32'h12345678}));
    clock_step();

    // ld.b at byte 2, data in the second MEM cycle.
    apply_stimulus(1'b1, 32'h1c000010, mk_zip(1'b1, 3'd1, 1'b1, 5'd7, 32'h00001002), 1'b0, '0, 1'b1);
    clock_step();
    apply_stimulus(1'b0, '0, '0, 1'b0, 32'h00800000, 1'b1);
    check_output("ldb_block", 64'(mem_ld_block), 64'd1);
    clock_step();
    apply_stimulus(1'b0, '0, '0, 1'b1, 32'h00800000, 1'b1);
    check_output("ldb_data", 64'(mem_rf_zip[31:0]), 64'h00000000FFFFFF80);
    check_output("ldb_unblock", 64'(mem_ld_block), 64'd0);
    clock_step();

    // ld.hu upper half, buffered while WB stalls.
    apply_stimulus(1'b1, 32'h1c000020, mk_zip(1'b1, 3'd4, 1'b1, 5'd9, 32'h00002002), 1'b0, '0, 1'b1);
    clock_step();
    apply_stimulus(1'b0, '0, '0, 1'b1, 32'hBEEF0000, 1'b0);
    clock_step();
    apply_stimulus(1'b1, 32'h1c000024, mk_zip(1'b0, 3'd0, 1'b1, 5'd1, 32'h11111111), 1'b0, '0, 1'b0);
    check_output("ldhu_hold", 64'(mem_rf_zip[31:0]), 64'h0000BEEF);
    check_output("ldhu_noallow", 64'(mem_allowin), 64'd0);
    clock_step();
    apply_stimulus(1'b0, '0, '0, 1'b1, 32'h0, 1'b1);
    check_output("ldhu_keep", 64'(mem_rf_zip[31:0]), 64'h0000BEEF);
    check_output("ldhu_allow", 64'(mem_allowin), 64'd1);
    clock_step();

    // Three ALU ops streaming through without bubbles.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(k < 3, 32'h100 + 32'(4 * k), mk_zip(1'b0, 3'd0, 1'b1, 5'(k + 2), 32'(k)), 1'b0, '0, 1'b1);
      if (k > 0) begin
        check_output("stream_valid", 64'(mem_to_wb_valid), 64'd1);
        check_output("stream_pc", 64'(mem_pc), 64'(32'h100 + 32'(4 * (k - 1))));
      end
      clock_step();
    end

    // Reset while a load waits; later data_ok must be ignored.
    apply_stimulus(1'b1, 32'h200, mk_zip(1'b1, 3'd0, 1'b1, 5'd3, 32'h40), 1'b0, '0, 1'b1);
    clock_step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    clock_step();
    async_reset_check("wait_reset");
    apply_stimulus(1'b0, '0, '0, 1'b1, 32'hCAFEF00D, 1'b1);
    check_output("post_reset_to_wb", 64'(mem_to_wb_valid), 64'd0);
    check_output("post_reset_allow", 64'(mem_allowin), 64'd1);
    clock_step();

    // Stray data_ok with nothing in MEM.
    apply_stimulus(1'b0, '0, '0, 1'b1, 32'hDEADBEEF, 1'b1);
    check_output("stray_to_wb", 64'(mem_to_wb_valid), 64'd0);
    check_output("stray_block", 64'(mem_ld_block), 64'd0);
    clock_step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    check_output("stray_after", 64'(mem_to_wb_valid), 64'd0);
    clock_step();

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) async_reset_check("rand_reset");
      z = mk_zip(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom);
      apply_stimulus($urandom_range(0, 3) != 0, $urandom, z, $urandom_range(0, 2) == 0,
                     $urandom, $urandom_range(0, 3) != 0);
      clock_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
